// File: rtl/wb_ddr_tester_pkg.sv
// Shared types and helpers for the Wishbone DDR write/readback tester.
//   state_e         : tester sequencer states
//   LFSR_POLY       : Galois feedback polynomial (shift right)
//   lfsr_next()     : one LFSR step
//   seed_sanitise() : maps the all-zero seed (LFSR lock-up) to 1
package wb_ddr_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WGAP,
        ST_READ,
        ST_DONE
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_POLY;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] seed_sanitise(input logic [31:0] raw);
        return (raw == '0) ? 32'h0000_0001 : raw;
    endfunction

endpackage

// File: rtl/ddr_tester_lfsr.sv
// 32-bit Galois LFSR used as the write-data generator and the read-data checker.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (state resets to 0)
//   load       : load load_val (has priority over step)
//   load_val   : value to load (already sanitised by the caller)
//   step       : advance one LFSR step
//   lfsr_state : current (registered) LFSR state
module ddr_tester_lfsr
    import wb_ddr_tester_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    output logic [31:0] lfsr_state
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_state = lfsr_q;

endmodule

// File: rtl/wb_ddr_tester.sv
// Pipelined Wishbone initiator running a write-then-readback LFSR memory test.
// Optional feature: define WB_DDR_TESTER_TIMEOUT_EN to build the ack watchdog.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   start, base_adr, num_words, seed    : test request and its parameters
//   busy, done, err_cnt, first_fail_adr : test status
//   bus_err, timeout                    : abnormal termination flags
//   wb_cyc/stb/we/adr/dat_w/sel         : registered Wishbone master outputs
//   wb_dat_r, wb_ack, wb_err, wb_stall  : Wishbone responder inputs
module wb_ddr_tester
    import wb_ddr_tester_pkg::*;
#(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_fail_adr,
    output logic              bus_err,
    output logic              timeout,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_adr,
    output logic [31:0]       wb_dat_w,
    output logic [3:0]        wb_sel,
    input  logic [31:0]       wb_dat_r,
    input  logic              wb_ack,
    input  logic              wb_err,
    input  logic              wb_stall
);

    localparam logic [3:0]        MAX_O = 4'(MAX_OUTST);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, num_q, num_d;
    logic [ADDR_W-1:0] issue_q, issue_d, ackn_q, ackn_d;
    logic [ADDR_W-1:0] adr_q, adr_d, ffa_q, ffa_d;
    logic [31:0]       seed_q, seed_d;
    logic [3:0]        outst_q, outst_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              bus_err_q, bus_err_d, timeout_q, timeout_d;

    logic        start_ok, xfer, active, accept, ack_ev, err_ev, last_ack;
    logic        lfsr_load, mismatch, to_fire;
    logic [31:0] lfsr_load_val, wr_data, chk_data;

    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign xfer      = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign active    = xfer || (state_q == ST_WGAP);
    assign accept    = stb_q && !wb_stall;
    assign ack_ev    = cyc_q && wb_ack;
    assign err_ev    = active && wb_err;
    assign last_ack  = ack_ev && ((ackn_q + ONE_A) == num_q);
    assign mismatch  = ack_ev && (state_q == ST_READ) && (wb_dat_r != chk_data);

    // Both generators restart from the seed at test start and again in WGAP,
    // so the checker regenerates exactly the sequence that was written.
    assign lfsr_load     = start_ok || (state_q == ST_WGAP);
    assign lfsr_load_val = start_ok ? seed_sanitise(seed) : seed_q;

    ddr_tester_lfsr u_wr_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lfsr_load),
        .load_val   (lfsr_load_val),
        .step       (accept && (state_q == ST_WRITE)),
        .lfsr_state (wr_data)
    );

    ddr_tester_lfsr u_chk_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lfsr_load),
        .load_val   (lfsr_load_val),
        .step       (ack_ev && (state_q == ST_READ)),
        .lfsr_state (chk_data)
    );

`ifdef WB_DDR_TESTER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        if (xfer && (outst_q != '0) && !ack_ev) begin
            to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign to_fire = xfer && (to_cnt_q == '1);
`else
    logic [TIMEOUT_W-1:0] timeout_w_unused;
    assign timeout_w_unused = '0;
    assign to_fire          = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (num_words == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (err_ev || to_fire) begin
                    state_d = ST_DONE;
                end else if (last_ack) begin
                    state_d = ST_WGAP;
                end
            end
            ST_WGAP: state_d = err_ev ? ST_DONE : ST_READ;
            ST_READ: begin
                if (err_ev || to_fire || last_ack) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs. Bus outputs are derived from the next
    // state and next counters so they are flops yet still reflect the issue
    // rules in the cycle they are visible.
    always_comb begin
        base_d    = base_q;
        num_d     = num_q;
        seed_d    = seed_q;
        issue_d   = issue_q;
        ackn_d    = ackn_q;
        adr_d     = adr_q;
        ffa_d     = ffa_q;
        outst_d   = outst_q;
        err_cnt_d = err_cnt_q;
        bus_err_d = bus_err_q;
        timeout_d = timeout_q;

        if (start_ok) begin
            base_d    = base_adr;
            num_d     = num_words;
            seed_d    = seed_sanitise(seed);
            issue_d   = '0;
            ackn_d    = '0;
            adr_d     = base_adr;
            ffa_d     = '0;
            outst_d   = '0;
            err_cnt_d = '0;
            bus_err_d = 1'b0;
            timeout_d = 1'b0;
        end else begin
            if (xfer) begin
                if (accept) begin
                    issue_d = issue_q + ONE_A;
                    adr_d   = adr_q + ONE_A;
                end
                if (ack_ev) begin
                    ackn_d = ackn_q + ONE_A;
                end
                unique case ({accept, ack_ev})
                    2'b10:   outst_d = outst_q + 4'd1;
                    2'b01:   outst_d = outst_q - 4'd1;
                    default: outst_d = outst_q;
                endcase
                if (mismatch) begin
                    if (err_cnt_q == '0) begin
                        ffa_d = base_q + ackn_q;
                    end
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
            end
            if (state_q == ST_WGAP) begin
                issue_d = '0;
                ackn_d  = '0;
                adr_d   = base_q;
                outst_d = '0;
            end
            if (err_ev) begin
                bus_err_d = 1'b1;
            end
            if (to_fire) begin
                timeout_d = 1'b1;
            end
        end

        cyc_d  = (state_d == ST_WRITE) || (state_d == ST_READ);
        stb_d  = cyc_d && (issue_d < num_d) && (outst_d < MAX_O);
        we_d   = (state_d == ST_WRITE);
        sel_d  = cyc_d ? 4'hF : 4'h0;
        busy_d = cyc_d || (state_d == ST_WGAP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            num_q     <= '0;
            seed_q    <= '0;
            issue_q   <= '0;
            ackn_q    <= '0;
            adr_q     <= '0;
            ffa_q     <= '0;
            outst_q   <= '0;
            err_cnt_q <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            seed_q    <= seed_d;
            issue_q   <= issue_d;
            ackn_q    <= ackn_d;
            adr_q     <= adr_d;
            ffa_q     <= ffa_d;
            outst_q   <= outst_d;
            err_cnt_q <= err_cnt_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bus_err_q <= bus_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_cnt_q;
    assign first_fail_adr = ffa_q;
    assign bus_err        = bus_err_q;
    assign timeout        = timeout_q;
    assign wb_cyc         = cyc_q;
    assign wb_stb         = stb_q;
    assign wb_we          = we_q;
    assign wb_adr         = adr_q;
    assign wb_dat_w       = wr_data;
    assign wb_sel         = sel_q;

endmodule

// File: tb/tb_wb_ddr_tester.sv
// Self-checking bench for wb_ddr_tester: a Wishbone responder model with
// configurable stall/latency/fault injection plus a transaction scoreboard.
module tb_wb_ddr_tester;

    localparam int unsigned AW = 30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_adr = '0;
    logic [AW-1:0] num_words = '0;
    logic [31:0]   seed = '0;
    logic          busy, done, bus_err, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_fail_adr;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [31:0]   wb_dat_w;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dat_r = '0;
    logic          wb_ack = 1'b0, wb_err = 1'b0, wb_stall = 1'b0;

    always #5 clk = ~clk;

    wb_ddr_tester #(
        .ADDR_W    (AW),
        .MAX_OUTST (4),
`ifdef WB_DDR_TESTER_TIMEOUT_EN
        .TIMEOUT_W (4)
`else
        .TIMEOUT_W (16)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_adr       (base_adr),
        .num_words      (num_words),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_fail_adr (first_fail_adr),
        .bus_err        (bus_err),
        .timeout        (timeout),
        .wb_cyc         (wb_cyc),
        .wb_stb         (wb_stb),
        .wb_we          (wb_we),
        .wb_adr         (wb_adr),
        .wb_dat_w       (wb_dat_w),
        .wb_sel         (wb_sel),
        .wb_dat_r       (wb_dat_r),
        .wb_ack         (wb_ack),
        .wb_err         (wb_err),
        .wb_stall       (wb_stall)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } txn_t;

    typedef struct {
        int unsigned due;
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    txn_t        exp_q[$];
    rsp_t        pend[$];
    logic [31:0] mem [logic [AW-1:0]];

    int n_cmp = 0;
    int n_bad = 0;

    // Responder configuration.
    int unsigned stall_pct = 0;
    int unsigned lat = 1;
    bit          never_ack = 0;
    int          err_wr_idx = -1;
    int          flip_a = -1;
    int          flip_b = -1;

    // Responder observations.
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int unsigned cyc_n = 0;
    bit          cyc_seen = 0;
    bit          err_chk = 0;
    bit          stalled_stb = 0;
    logic [AW-1:0] prev_adr;
    logic [31:0]   prev_dat;

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] t;
        t = {1'b0, s[31:1]};
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    // Responder + scoreboard, evaluated mid-cycle so DUT outputs are stable.
    always @(negedge clk) begin
        txn_t e;
        rsp_t r;
        cyc_n++;
        if (err_chk) begin
            n_cmp++;
            if (wb_cyc !== 1'b0) begin
                n_bad++;
                $display("FAIL err_drop: wb_cyc=%b required 0 after err", wb_cyc);
            end
            err_chk = 0;
        end
        if (wb_cyc === 1'b1) cyc_seen = 1;
        if (stalled_stb && rst_n) begin
            n_cmp++;
            if (wb_stb !== 1'b1 || wb_adr !== prev_adr || wb_dat_w !== prev_dat) begin
                n_bad++;
                $display("FAIL stall_hold: stb=%b adr=%h dat=%h required 1 %h %h",
                         wb_stb, wb_adr, wb_dat_w, prev_adr, prev_dat);
            end
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
        if (!wb_cyc || !rst_n) begin
            pend.delete();
        end else if (pend.size() > 0 && !never_ack && pend[0].due <= cyc_n) begin
            r = pend.pop_front();
            if (r.err) begin
                wb_err  = 1'b1;
                err_chk = 1;
            end else begin
                wb_ack   = 1'b1;
                wb_dat_r = r.dat;
            end
        end
        wb_stall    = ($urandom_range(99) < stall_pct);
        stalled_stb = rst_n && wb_cyc && wb_stb && wb_stall && !wb_err;
        prev_adr    = wb_adr;
        prev_dat    = wb_dat_w;
        if (rst_n && wb_cyc && wb_stb && !wb_stall) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL txn_extra: we=%b adr=%h not expected", wb_we, wb_adr);
            end else begin
                e = exp_q.pop_front();
                if (wb_we !== e.we || wb_adr !== e.adr || (e.we && wb_dat_w !== e.dat)) begin
                    n_bad++;
                    $display("FAIL txn: we=%b adr=%h dat=%h required we=%b adr=%h dat=%h",
                             wb_we, wb_adr, wb_dat_w, e.we, e.adr, e.dat);
                end
            end
            if (wb_we) begin
                mem[wb_adr] = wb_dat_w;
                r.dat = '0;
                r.err = (wr_cnt == err_wr_idx);
                wr_cnt++;
            end else begin
                r.dat = mem.exists(wb_adr) ? mem[wb_adr] : 32'hDEAD_BEEF;
                if (rd_cnt == flip_a || rd_cnt == flip_b) r.dat = r.dat ^ 32'h1;
                r.err = 1'b0;
                rd_cnt++;
            end
            r.due = cyc_n + lat;
            pend.push_back(r);
            n_cmp++;
            if (pend.size() > 4) begin
                n_bad++;
                $display("FAIL outstanding: %0d required <= 4", pend.size());
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n,
                            input logic [31:0] sd);
        logic [31:0] s;
        txn_t t;
        exp_q.delete();
        mem.delete();
        s = (sd == 32'h0) ? 32'h1 : sd;
        for (int unsigned i = 0; i < n; i++) begin
            t.we = 1'b1; t.adr = b + AW'(i); t.dat = s;
            exp_q.push_back(t);
            s = model_step(s);
        end
        for (int unsigned i = 0; i < n; i++) begin
            t.we = 1'b0; t.adr = b + AW'(i); t.dat = '0;
            exp_q.push_back(t);
        end
        @(negedge clk);
        wr_cnt = 0; rd_cnt = 0; cyc_seen = 0;
        base_adr = b; num_words = n; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, bus_err, timeout, err_cnt, first_fail_adr,
             wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel} !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: busy=%b done=%b cyc=%b stb=%b adr=%h dat=%h sel=%h required all 0",
                     busy, done, wb_cyc, wb_stb, wb_adr, wb_dat_w, wb_sel);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        bit ok;
        stall_pct = 0; lat = 1;
        do_start(30'h100, 30'd16, 32'h1234);
        n_cmp++;
        if (wb_stb !== 1'b1 || busy !== 1'b1 || wb_adr !== 30'h100 || wb_dat_w !== 32'h1234
            || wb_we !== 1'b1 || wb_sel !== 4'hF) begin
            n_bad++;
            $display("FAIL first_stb: stb=%b busy=%b adr=%h dat=%h we=%b sel=%h required 1 1 100 1234 1 f",
                     wb_stb, busy, wb_adr, wb_dat_w, wb_we, wb_sel);
        end
        wait_done(400, ok);
        n_cmp++;
        if (!ok || err_cnt !== 16'd0 || bus_err !== 1'b0 || busy !== 1'b0
            || wr_cnt != 16 || rd_cnt != 16 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL zero_wait: done=%b err_cnt=%0d bus_err=%b wr=%0d rd=%0d left=%0d required 1 0 0 16 16 0",
                     done, err_cnt, bus_err, wr_cnt, rd_cnt, exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        stall_pct = 50; lat = 3;
        do_start(30'h100, 30'd64, 32'h1234);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL restart: done=%b busy=%b required 0 1", done, busy);
        end
        repeat (5) @(negedge clk);
        // start while busy must be ignored; the scoreboard catches any restart
        base_adr = 30'h0; num_words = 30'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, ok);
        n_cmp++;
        if (!ok || err_cnt !== 16'd0 || bus_err !== 1'b0 || wr_cnt != 64 || rd_cnt != 64) begin
            n_bad++;
            $display("FAIL stall_run: done=%b err_cnt=%0d wr=%0d rd=%0d required 1 0 64 64",
                     done, err_cnt, wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_bitflip();
        bit ok;
        stall_pct = 0; lat = 1; flip_a = 5; flip_b = 9;
        do_start(30'h40, 30'd16, 32'hCAFE_0001);
        wait_done(400, ok);
        n_cmp++;
        if (!ok || err_cnt !== 16'd2 || first_fail_adr !== 30'h45) begin
            n_bad++;
            $display("FAIL bitflip: done=%b err_cnt=%0d ffa=%h required 1 2 45",
                     done, err_cnt, first_fail_adr);
        end
        flip_a = -1; flip_b = -1;
    endtask

    task automatic test_bus_err();
        bit ok;
        stall_pct = 0; lat = 1; err_wr_idx = 3;
        do_start(30'h200, 30'd16, 32'h5555_AAAA);
        wait_done(400, ok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok || bus_err !== 1'b1 || done !== 1'b1 || busy !== 1'b0
            || rd_cnt != 0 || wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL bus_err: done=%b bus_err=%b busy=%b rd=%0d cyc=%b required 1 1 0 0 0",
                     done, bus_err, busy, rd_cnt, wb_cyc);
        end
        err_wr_idx = -1;
    endtask

    task automatic test_zero_words();
        stall_pct = 0; lat = 1;
        do_start(30'h300, 30'd0, 32'h9);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || err_cnt !== 16'd0 || bus_err !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_words: done=%b busy=%b err_cnt=%0d bus_err=%b required 1 0 0 0",
                     done, busy, err_cnt, bus_err);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (cyc_seen) begin
            n_bad++;
            $display("FAIL zero_words_cyc: wb_cyc seen=1 required 0");
        end
    endtask

    task automatic test_wrap();
        bit ok;
        stall_pct = 25; lat = 6;
        do_start(30'h3FFF_FFFE, 30'd4, 32'h0);
        wait_done(400, ok);
        n_cmp++;
        if (!ok || err_cnt !== 16'd0 || wr_cnt != 4 || rd_cnt != 4 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL wrap: done=%b err_cnt=%0d wr=%0d rd=%0d left=%0d required 1 0 4 4 0",
                     done, err_cnt, wr_cnt, rd_cnt, exp_q.size());
        end
    endtask

`ifdef WB_DDR_TESTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        stall_pct = 0; lat = 1; never_ack = 1;
        do_start(30'h500, 30'd8, 32'h77);
        wait_done(60, ok);
        n_cmp++;
        if (!ok || timeout !== 1'b1 || wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout: done=%b timeout=%b cyc=%b required 1 1 0", done, timeout, wb_cyc);
        end
        never_ack = 0;
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        stall_pct = 0; lat = 2;
        do_start(30'h600, 30'd32, 32'hABCD);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (wb_cyc === 1'b1 && wb_we === 1'b0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL read_phase: never reached read phase, required within 500 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, bus_err, timeout, err_cnt, first_fail_adr,
             wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b cyc=%b stb=%b adr=%h dat=%h required all 0",
                     busy, wb_cyc, wb_stb, wb_adr, wb_dat_w);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: busy=%b done=%b cyc=%b required 0 0 0", busy, done, wb_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_bitflip();
        test_bus_err();
        test_zero_words();
        test_wrap();
`ifdef WB_DDR_TESTER_TIMEOUT_EN
        test_timeout();
`else
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_tied: timeout=%b required 0", timeout);
        end
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
